filter_cmd_ctrl: RTL and testbench
==================================

Name: filter_cmd_ctrl

Overview:
- Consumes the debounced push-button levels from the front-panel debouncers and turns them into coprocessor commands.
- Selects the filter and matrix size, issues a one-cycle start to the coprocessor, tracks busy/done/timeout and supports abort.
- Sits between the per-button debouncers (upstream) and the coprocessor control interface and status LEDs (downstream).

Parameters:
- NUM_FILTERS, 5, number of selectable filters; filter_sel wraps within 0..NUM_FILTERS-1.
- NUM_SIZES, 4, number of selectable matrix sizes; size_sel wraps within 0..NUM_SIZES-1.
- TIMEOUT_CYCLES, 50000000, clk cycles allowed in WAIT_DONE before error (1 s at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- btn_next  in  1  debounced level: next filter.
- btn_prev  in  1  debounced level: previous filter.
- btn_size  in  1  debounced level: cycle matrix size.
- btn_start  in  1  debounced level: launch operation.
- btn_abort  in  1  debounced level: abort or clear error.
- cop_done  in  1  coprocessor completion pulse/level.
- filter_sel  out  3  current filter index.
- size_sel  out  2  current matrix size index.
- cop_start  out  1  one-cycle start strobe.
- cop_filter  out  3  filter latched at start, stable while busy.
- cop_size  out  2  size latched at start, stable while busy.
- busy  out  1  operation in flight.
- done_flag  out  1  last operation completed OK.
- err_flag  out  1  last operation timed out or was aborted.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n). All registers clear on a clk edge where rst_n=0.
- Reset values: filter_sel=0, size_sel=0, cop_filter=0, cop_size=0, cop_start=0, busy=0, done_flag=0, err_flag=0, state=IDLE, timeout counter=0.
- Button input stage:
  - Each btn_* passes through a 2-FF synchronizer (the debounced levels come from a divided clock).
  - A rising-edge detector follows; its "previous" register resets to 1, so a button held through reset produces no event.
  - Each press yields exactly one 1-cycle event, however long the level is held.
- Latency: btn level first sampled high at edge k, action register updates at edge k+2; cop_start is high during cycle k+2..k+3 for a start press.
- Selection (IDLE only):
  - next: filter_sel+1, wraps NUM_FILTERS-1 -> 0.
  - prev: filter_sel-1, wraps 0 -> NUM_FILTERS-1.
  - size: size_sel+1, wraps NUM_SIZES-1 -> 0.
  - next and prev events in the same cycle cancel (no change). size is independent and may coincide with next or prev.
- Selection in other states: next/prev/size events are ignored in ISSUE, WAIT_DONE and ERROR (discarded, not queued).
- FSM IDLE:
  - start event -> ISSUE. Latch cop_filter/cop_size from filter_sel/size_sel; clear done_flag and err_flag.
  - start has priority over next/prev/size in the same cycle; selection changes are dropped.
  - abort event in IDLE clears done_flag and err_flag only.
- FSM ISSUE (1 cycle): cop_start=1, busy=1, timeout counter cleared; -> WAIT_DONE.
- FSM WAIT_DONE: busy=1; counter increments each cycle. Evaluated in priority order:
  - cop_done=1 -> IDLE, done_flag=1.
  - else abort event -> ERROR, err_flag=1.
  - else counter==TIMEOUT_CYCLES-1 -> ERROR, err_flag=1.
  - cop_done wins over simultaneous abort or timeout.
  - cop_done is ignored outside WAIT_DONE.
- FSM ERROR: busy=0, err_flag=1. An abort or start event -> IDLE with err_flag cleared. A start here does not launch an operation.
- Reset mid-operation: returns to IDLE with no cop_start; a later cop_done is ignored.
- Width rules: counter width is $clog2(TIMEOUT_CYCLES+1); selection arithmetic is modulo per the wrap rules; NUM_FILTERS<=8 and NUM_SIZES<=4 are checked at elaboration.

Decomposition:
- Shared package constants:
  - FSM state encoding: IDLE=0, ISSUE=1, WAIT_DONE=2, ERROR=3.
  - Filter index constants: SOBEL=0, PREWITT=1, ROBERTS=2, LAPLACE=3, MEAN=4.
  - Size index constants: 3x3=0, 5x5=1, 7x7=2, 9x9=3.
  - FILTER_W=3, SIZE_W=2.
- One sub-module, btn_event: 2-FF synchronizer plus rising-edge detector, instantiated once per button.

Test Plan:
- Reset with btn_next held high, release, press again -> no event on release; the second press gives filter_sel=1 exactly 2 edges after sampling.
- Hold btn_next high for 1000 cycles, then press 5 more times -> filter_sel goes 1 (single event for the long hold), then 2,3,4,0,1; one prev from 0 -> 4.
- Set filter 3, size 2, press start -> cop_start high exactly 1 cycle, cop_filter=3, cop_size=2, busy=1; next press while busy leaves filter_sel=3; cop_done 20 cycles later -> busy=0, done_flag=1.
- With TIMEOUT_CYCLES=100, start and withhold cop_done -> err_flag=1, busy=0 exactly 100 cycles after entering WAIT_DONE; abort -> IDLE, err_flag=0.
- In WAIT_DONE, cop_done and abort event in the same cycle -> done_flag=1, err_flag=0, state IDLE.
- Assert rst_n=0 for one edge during WAIT_DONE, then pulse cop_done -> all outputs at reset values, done_flag stays 0; next and prev in the same cycle in IDLE -> filter_sel unchanged.

Source files
------------

// File: rtl/filter_cmd_ctrl_pkg.sv
// Shared constants and types for the filter command controller.
package filter_cmd_ctrl_pkg;

  localparam int unsigned FILTER_W = 3;
  localparam int unsigned SIZE_W   = 2;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitDone = 2'd2,
    StError    = 2'd3
  } state_e;

  localparam logic [FILTER_W-1:0] FiltSobel   = 3'd0;
  localparam logic [FILTER_W-1:0] FiltPrewitt = 3'd1;
  localparam logic [FILTER_W-1:0] FiltRoberts = 3'd2;
  localparam logic [FILTER_W-1:0] FiltLaplace = 3'd3;
  localparam logic [FILTER_W-1:0] FiltMean    = 3'd4;

  localparam logic [SIZE_W-1:0] Size3x3 = 2'd0;
  localparam logic [SIZE_W-1:0] Size5x5 = 2'd1;
  localparam logic [SIZE_W-1:0] Size7x7 = 2'd2;
  localparam logic [SIZE_W-1:0] Size9x9 = 2'd3;

  // Bit positions of the buttons in the internal event vector.
  localparam int unsigned BtnNext  = 0;
  localparam int unsigned BtnPrev  = 1;
  localparam int unsigned BtnSize  = 2;
  localparam int unsigned BtnStart = 3;
  localparam int unsigned BtnAbort = 4;
  localparam int unsigned NumBtns  = 5;

endpackage

// File: rtl/filter_cmd_ctrl_btn_event.sv
// Two-flop synchronizer followed by a rising-edge detector for one button level.
module filter_cmd_ctrl_btn_event (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic evt_o
);

  logic sync1_q, sync2_q, prev_q;

  // All stages reset high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign evt_o = sync2_q & ~prev_q;

endmodule

// File: rtl/filter_cmd_ctrl.sv
// Front-panel command controller: button events select filter/size and launch the coprocessor.
module filter_cmd_ctrl
  import filter_cmd_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FILTERS    = 5,
  parameter int unsigned NUM_SIZES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_next,
  input  logic                btn_prev,
  input  logic                btn_size,
  input  logic                btn_start,
  input  logic                btn_abort,
  input  logic                cop_done,
  output logic [FILTER_W-1:0] filter_sel,
  output logic [SIZE_W-1:0]   size_sel,
  output logic                cop_start,
  output logic [FILTER_W-1:0] cop_filter,
  output logic [SIZE_W-1:0]   cop_size,
  output logic                busy,
  output logic                done_flag,
  output logic                err_flag
);

  localparam int unsigned         CntW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0]     CntLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [FILTER_W-1:0] FiltLast = FILTER_W'(NUM_FILTERS - 1);
  localparam logic [SIZE_W-1:0]   SizeLast = SIZE_W'(NUM_SIZES - 1);

  if (NUM_FILTERS < 1 || NUM_FILTERS > 8) begin : g_bad_num_filters
    $error("NUM_FILTERS must be in 1..8");
  end
  if (NUM_SIZES < 1 || NUM_SIZES > 4) begin : g_bad_num_sizes
    $error("NUM_SIZES must be in 1..4");
  end

  logic [NumBtns-1:0] btn_lvl, evt;

  assign btn_lvl = {btn_abort, btn_start, btn_size, btn_prev, btn_next};

  for (genvar i = 0; i < NumBtns; i++) begin : g_btn
    filter_cmd_ctrl_btn_event u_btn_event (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (btn_lvl[i]),
      .evt_o (evt[i])
    );
  end

  state_e              state_q, state_d;
  logic [FILTER_W-1:0] filter_q, filter_d, cop_filter_q, cop_filter_d;
  logic [SIZE_W-1:0]   size_q, size_d, cop_size_q, cop_size_d;
  logic                done_q, done_d, err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      filter_q     <= '0;
      size_q       <= '0;
      cop_filter_q <= '0;
      cop_size_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      filter_q     <= filter_d;
      size_q       <= size_d;
      cop_filter_q <= cop_filter_d;
      cop_size_q   <= cop_size_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    filter_d     = filter_q;
    size_d       = size_q;
    cop_filter_d = cop_filter_q;
    cop_size_d   = cop_size_q;
    done_d       = done_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (evt[BtnStart]) begin
          // Start wins; any coincident selection change is dropped.
          state_d      = StIssue;
          cop_filter_d = filter_q;
          cop_size_d   = size_q;
          done_d       = 1'b0;
          err_d        = 1'b0;
        end else begin
          if (evt[BtnAbort]) begin
            done_d = 1'b0;
            err_d  = 1'b0;
          end
          if (evt[BtnNext] && !evt[BtnPrev]) begin
            filter_d = (filter_q == FiltLast) ? '0 : filter_q + FILTER_W'(1);
          end else if (evt[BtnPrev] && !evt[BtnNext]) begin
            filter_d = (filter_q == '0) ? FiltLast : filter_q - FILTER_W'(1);
          end
          if (evt[BtnSize]) begin
            size_d = (size_q == SizeLast) ? '0 : size_q + SIZE_W'(1);
          end
        end
      end
      StIssue: begin
        state_d = StWaitDone;
        cnt_d   = '0;
      end
      StWaitDone: begin
        cnt_d = cnt_q + CntW'(1);
        if (cop_done) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (evt[BtnAbort] || cnt_q == CntLast) begin
          state_d = StError;
          err_d   = 1'b1;
        end
      end
      StError: begin
        if (evt[BtnAbort] || evt[BtnStart]) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign filter_sel = filter_q;
  assign size_sel   = size_q;
  assign cop_filter = cop_filter_q;
  assign cop_size   = cop_size_q;
  assign cop_start  = (state_q == StIssue);
  assign busy       = (state_q == StIssue) || (state_q == StWaitDone);
  assign done_flag  = done_q;
  assign err_flag   = err_q;

endmodule

// File: tb/tb_filter_cmd_ctrl.sv
// Bench for filter_cmd_ctrl: vector table, directed corner cases, random run against a model.
module tb_filter_cmd_ctrl;

  localparam int unsigned T = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_next = 1'b0, btn_prev = 1'b0, btn_size = 1'b0;
  logic       btn_start = 1'b0, btn_abort = 1'b0, cop_done = 1'b0;
  logic [2:0] filter_sel, cop_filter;
  logic [1:0] size_sel, cop_size;
  logic       cop_start, busy, done_flag, err_flag;

  always #5 clk = ~clk;

  filter_cmd_ctrl #(
    .NUM_FILTERS    (5),
    .NUM_SIZES      (4),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .btn_size   (btn_size),
    .btn_start  (btn_start),
    .btn_abort  (btn_abort),
    .cop_done   (cop_done),
    .filter_sel (filter_sel),
    .size_sel   (size_sel),
    .cop_start  (cop_start),
    .cop_filter (cop_filter),
    .cop_size   (cop_size),
    .busy       (busy),
    .done_flag  (done_flag),
    .err_flag   (err_flag)
  );

  // Button bit order: {abort, start, size, prev, next}
  localparam bit [4:0] NXT = 5'b00001, PRV = 5'b00010, SZ = 5'b00100,
                       STA = 5'b01000, ABT = 5'b10000;

  int n_vec = 0;
  int n_bad = 0;
  bit model_on = 1'b0;

  wire [13:0] dut_out = {filter_sel, size_sel, cop_start, cop_filter, cop_size,
                         busy, done_flag, err_flag};

  function automatic logic [13:0] pack(int f, int s, bit st, int cf, int cs, bit b, bit d,
                                       bit e);
    return {3'(f), 2'(s), st, 3'(cf), 2'(cs), b, d, e};
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level history per button, abstract operation flags.
  bit [4:0] h1, h2, h3;
  int m_f, m_s, m_cf, m_cs, m_cnt;
  bit m_launch, m_wait, m_fault, m_done, m_err;

  task automatic model_reset();
    h1 = '1; h2 = '1; h3 = '1;
    m_f = 0; m_s = 0; m_cf = 0; m_cs = 0; m_cnt = 0;
    m_launch = 0; m_wait = 0; m_fault = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit [4:0] ev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev = h2 & ~h3;  // level seen two edges ago rose relative to the one before
    h3 = h2;
    h2 = h1;
    h1 = {btn_abort, btn_start, btn_size, btn_prev, btn_next};
    if (m_launch) begin
      m_launch = 0; m_wait = 1; m_cnt = 0;
    end else if (m_wait) begin
      m_cnt++;
      if (cop_done) begin
        m_wait = 0; m_done = 1;
      end else if (ev[4] || m_cnt == T) begin
        m_wait = 0; m_fault = 1; m_err = 1;
      end
    end else if (m_fault) begin
      if (ev[4] || ev[3]) begin
        m_fault = 0; m_err = 0;
      end
    end else if (ev[3]) begin
      m_launch = 1; m_cf = m_f; m_cs = m_s; m_done = 0; m_err = 0;
    end else begin
      if (ev[4]) begin
        m_done = 0; m_err = 0;
      end
      if (ev[0] && !ev[1]) m_f = (m_f + 1) % 5;
      if (ev[1] && !ev[0]) m_f = (m_f + 4) % 5;
      if (ev[2]) m_s = (m_s + 1) % 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (model_on)
      check("model", int'(dut_out),
            int'(pack(m_f, m_s, m_launch, m_cf, m_cs, m_launch | m_wait, m_done, m_err)));
  endtask

  task automatic set_btn(bit [4:0] b);
    {btn_abort, btn_start, btn_size, btn_prev, btn_next} = b;
  endtask

  task automatic press(bit [4:0] b);
    set_btn(b);
    tick();
    set_btn('0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  // Press start and leave the DUT in its first WAIT_DONE cycle.
  task automatic launch();
    set_btn(STA);
    tick();
    set_btn('0);
    repeat (3) tick();
  endtask

  typedef struct {
    bit         rst;
    bit [4:0]   btn;
    bit         done;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit [4:0] btn, bit done, logic [13:0] exp);
    vec_t v;
    v.rst = rst; v.btn = btn; v.done = done; v.exp = exp;
    return v;
  endfunction

  initial begin
    tbl.push_back(mk(0, 0,   0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, NXT, 0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(1, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, PRV, 0, pack(1, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(1, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, PRV, 0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, SZ,  0, pack(4, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, NXT | PRV, 0, pack(4, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, STA, 0, pack(4, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 1, 1, 4, 1, 1, 0, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 1, 0, 4, 1, 1, 0, 0)));
    tbl.push_back(mk(1, 0,   1, pack(4, 1, 0, 4, 1, 0, 1, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 1, 0, 4, 1, 0, 1, 0)));
    tbl.push_back(mk(1, ABT, 0, pack(4, 1, 0, 4, 1, 0, 1, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 1, 0, 4, 1, 0, 1, 0)));
    tbl.push_back(mk(1, 0,   0, pack(4, 1, 0, 4, 1, 0, 0, 0)));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst;
      set_btn(tbl[i].btn);
      cop_done = tbl[i].done;
      tick();
      check($sformatf("tbl[%0d]", i), int'(dut_out), int'(tbl[i].exp));
    end
    set_btn('0);
    cop_done = 1'b0;
    model_on = 1'b1;

    // Button held through reset gives no event; a fresh press lands two edges later.
    rst_n = 1'b0;
    set_btn(NXT);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("held_reset", int'(filter_sel), 0);
    set_btn('0);
    repeat (4) tick();
    check("release_no_evt", int'(filter_sel), 0);
    set_btn(NXT);
    tick();
    tick();
    check("lat_k1", int'(filter_sel), 0);
    tick();
    check("lat_k2", int'(filter_sel), 1);
    set_btn('0);
    repeat (3) tick();

    // Long hold counts once, then wrap forwards and backwards.
    do_reset();
    set_btn(NXT);
    repeat (1000) tick();
    check("long_hold", int'(filter_sel), 1);
    set_btn('0);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      press(NXT);
      check($sformatf("next_%0d", i), int'(filter_sel), (2 + i) % 5);
    end
    press(PRV);
    check("prev_to_0", int'(filter_sel), 0);
    press(PRV);
    check("prev_wrap", int'(filter_sel), 4);

    // Launch with filter 3 / size 2, selection locked while busy, completion.
    do_reset();
    repeat (3) press(NXT);
    repeat (2) press(SZ);
    set_btn(STA);
    tick();
    set_btn('0);
    tick();
    check("start_k1", int'(cop_start), 0);
    tick();
    check("start_pulse", int'({cop_start, cop_filter, cop_size, busy}),
          int'({1'b1, 3'd3, 2'd2, 1'b1}));
    tick();
    check("start_one_cycle", int'({cop_start, busy}), int'(2'b01));
    press(NXT);
    check("sel_locked", int'(filter_sel), 3);
    repeat (14) tick();
    cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    check("op_done", int'({busy, done_flag, err_flag}), int'(3'b010));

    // Timeout lands exactly T cycles after entering WAIT_DONE.
    launch();
    check("done_cleared", int'(done_flag), 0);
    repeat (T - 1) tick();
    check("pre_timeout", int'({busy, err_flag}), int'(2'b10));
    tick();
    check("timeout", int'({busy, err_flag}), int'(2'b01));
    press(ABT);
    check("abort_clear", int'({busy, err_flag}), int'(2'b00));

    // cop_done beats a coincident abort event.
    launch();
    repeat (5) tick();
    set_btn(ABT);
    tick();
    set_btn('0);
    tick();
    cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    check("done_vs_abort", int'({busy, done_flag, err_flag}), int'(3'b010));
    tick();
    check("done_vs_abort_idle", int'({busy, err_flag}), int'(2'b00));

    // Reset mid-operation; late cop_done ignored; next+prev cancel.
    launch();
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    repeat (3) tick();
    check("reset_mid_op", int'(dut_out), 0);
    press(NXT | PRV);
    check("next_prev_cancel", int'(filter_sel), 0);

    // Random run against the model.
    for (int i = 0; i < 4000; i++) begin
      bit [4:0] lv;
      lv = {btn_abort, btn_start, btn_size, btn_prev, btn_next};
      for (int b = 0; b < 5; b++) if ($urandom % 8 == 0) lv[b] = ~lv[b];
      set_btn(lv);
      cop_done = ($urandom % 20 == 0);
      rst_n = ($urandom % 400 != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
